result_reader: RTL

- Drain sequencer sitting on the read side of the result register file.
- On a start pulse it walks the register read select from 0 to NUM_REGS-1 and samples each 32-bit result.
- Each result goes out on a valid/ready stream to the downstream transmit path, with a last flag on the final word.
- After the final handshake it can pulse the register file's clear_data so the file is ready for the next computation.

---
 rtl/result_reader.sv | 79 +++++++
 1 files changed

// File: rtl/result_reader.sv
// result_reader: drains the result register file onto a valid/ready stream, then optionally clears it
module result_reader #(
   parameter int NUM_REGS      = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int CLEAR_ON_DONE = 1
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  start,
   output logic [3:0]            out_sel,
   input  logic [DATA_WIDTH-1:0] reg_data,
   output logic                  clear_data,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_last,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [2:0] {IDLE, LOAD, SEND, CLEAR, DONE} state_t;
   localparam logic [3:0] LAST = 4'(NUM_REGS - 1);
   state_t state;
   // sweep sequencer; out_sel doubles as the word index so it can never pass LAST
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state      <= IDLE;
         out_sel    <= '0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         tx_last    <= 1'b0;
         clear_data <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         clear_data <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  out_sel <= '0;
                  busy    <= 1'b1;
                  state   <= LOAD;
               end
            LOAD: begin
               tx_data  <= reg_data;
               tx_valid <= 1'b1;
               tx_last  <= out_sel == LAST;
               state    <= SEND;
            end
            SEND:
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  if (out_sel == LAST) begin
                     tx_last <= 1'b0;
                     out_sel <= '0;
                     if (CLEAR_ON_DONE != 0) begin
                        clear_data <= 1'b1;
                        state      <= CLEAR;
                     end else begin
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end else begin
                     out_sel <= out_sel + 4'd1;
                     state   <= LOAD;
                  end
               end
            CLEAR: begin
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule
